// File: rtl/uart_sample_framer_if.sv
// Byte handshake between the sample framer and the shared uart_tx:
// one-cycle start pulse with data, busy flag back from the UART.
interface uart_sample_framer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/uart_sample_framer.sv
// Snapshots four calibrated CODEC channels on a decimated sample_clk edge and
// streams one 5-byte "CH<n><hi><lo>" frame per enabled channel to uart_tx.
module uart_sample_framer #(
  parameter int W        = 16,
  parameter int DECIMATE = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  input  logic [3:0]          ch_mask,
  uart_sample_framer_if.master tx,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          overrun_count
);

  localparam int DEC_W = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_sc_q;
  logic [DEC_W-1:0]    r_dec;
  logic [2:0]          r_b, w_b_nxt;
  logic [1:0]          r_ch, w_ch_nxt;
  logic [3:0]          r_mask;
  logic signed [W-1:0] r_smp [4];
  logic                w_edge, w_eligible, w_load, w_fire, w_done, w_has_hi;
  logic [1:0]          w_first_ch, w_hi_ch;
  logic [15:0]         w_smp16;
  logic [7:0]          w_byte;

  function automatic logic [15:0] sext16(input logic signed [W-1:0] s);
    return 16'(s);
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] b, input logic [1:0] ch,
                                            input logic [15:0] s);
    case (b)
      3'd0:    return 8'h43;
      3'd1:    return 8'h48;
      3'd2:    return 8'h30 + {6'd0, ch};
      3'd3:    return s[15:8];
      default: return s[7:0];
    endcase
  endfunction

  assign w_edge     = sample_clk & ~r_sc_q;
  assign w_eligible = w_edge && (r_dec == '0);
  assign w_smp16    = sext16(r_smp[r_ch]);
  assign w_byte     = frame_byte(r_b, r_ch, w_smp16);
  assign busy       = (r_state != IDLE);
  assign frame_done = w_done;

  // Lowest channel of the live mask, and next higher channel of the shadow mask
  always_comb begin
    w_first_ch = 2'd0;
    w_hi_ch    = r_ch;
    w_has_hi   = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (ch_mask[i]) w_first_ch = 2'(i);
      if (r_mask[i] && (i > int'(r_ch))) begin
        w_hi_ch  = 2'(i);
        w_has_hi = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_b_nxt     = r_b;
    w_ch_nxt    = r_ch;
    w_load      = 1'b0;
    w_fire      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: if (w_eligible && (ch_mask != 4'd0)) begin
        w_load      = 1'b1;
        w_ch_nxt    = w_first_ch;
        w_b_nxt     = 3'd0;
        w_state_nxt = SEND;
      end
      SEND: if (!tx.tx_busy) begin
        w_fire      = 1'b1;
        w_state_nxt = HOLD;
      end
      // HOLD gives uart_tx one cycle to raise tx_busy before WAIT looks at it
      HOLD: w_state_nxt = WAIT;
      WAIT: if (!tx.tx_busy) begin
        if (r_b < 3'd4) begin
          w_b_nxt     = r_b + 3'd1;
          w_state_nxt = SEND;
        end else if (w_has_hi) begin
          w_ch_nxt    = w_hi_ch;
          w_b_nxt     = 3'd0;
          w_state_nxt = SEND;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc_q        <= 1'b0;
      r_dec         <= '0;
      r_b           <= 3'd0;
      r_ch          <= 2'd0;
      r_mask        <= 4'd0;
      tx.tx_start   <= 1'b0;
      tx.tx_data    <= 8'h00;
      overrun_count <= 8'd0;
    end else begin
      r_sc_q      <= sample_clk;
      r_b         <= w_b_nxt;
      r_ch        <= w_ch_nxt;
      tx.tx_start <= w_fire;
      if (w_edge) r_dec <= (r_dec == DEC_W'(DECIMATE - 1)) ? '0 : r_dec + 1'b1;
      if (w_load) r_mask <= ch_mask;
      if (w_fire) tx.tx_data <= w_byte;
      if (w_eligible && (r_state != IDLE) && (overrun_count != 8'hFF))
        overrun_count <= overrun_count + 8'd1;
    end
  end

  // Shadow samples are pure data; they are only read after a load
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_smp[0] <= sample_in0;
      r_smp[1] <= sample_in1;
      r_smp[2] <= sample_in2;
      r_smp[3] <= sample_in3;
    end
  end

endmodule

// File: doc/uart_sample_framer.md
# uart_sample_framer

- Streams calibrated CODEC samples to the host over the shared `uart_tx` instance.
- Sits between the `input_cal` outputs and `uart_tx`. It owns the `tx_start` / `tx_data` handshake and replaces ad-hoc inline UART sequencing in `top`.
- Takes an atomic snapshot of all four channels on a decimated `sample_clk` rising edge, then emits one 5-byte frame per enabled channel.
- Counts snapshots lost because the previous burst was still transmitting.

## Interface
Parameters:
- `W`, 16: sample width; 8 < W ≤ 16. The framer always sends the 16-bit sign-extended sample.
- `DECIMATE`, 256: a snapshot is eligible on every DECIMATE-th `sample_clk` rising edge; must be ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock (12 MHz)
- `rst_n`  in  1  asynchronous active-low reset
- `sample_clk`  in  1  CODEC sample strobe, synchronous to `clk`
- `sample_in0`..`sample_in3`  in  W each  signed calibrated samples
- `ch_mask`  in  4  channel enables; bit n enables channel n; sampled at snapshot
- `tx_busy`  in  1  from `uart_tx`; high while a byte is shifting
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`
- `tx_data`  out  8  byte to send; valid while `tx_start` = 1
- `busy`  out  1  high from snapshot until the last byte completes
- `frame_done`  out  1  one-cycle pulse when a burst completes
- `overrun_count`  out  8  saturating count of dropped eligible snapshots

## Operation
Edge detection and decimation:
- `sc_q` is a register of `sample_clk`; an edge is `sample_clk & ~sc_q`.
- A decimation counter `dec` (0..DECIMATE-1) advances on every edge and wraps to 0.
- An edge is eligible when `dec` = 0 before the increment, so the first edge after reset is eligible.

Eligible-edge outcomes:
- If state = IDLE and `ch_mask` ≠ 0: latch all four samples and `ch_mask` into shadow registers, select the lowest enabled channel, go to SEND.
- If state = IDLE and `ch_mask` = 0: do nothing. No overrun is counted and `frame_done` does not pulse.
- If state ≠ IDLE: keep the shadow registers and increment `overrun_count` (saturates at 255).

Frame bytes, index b = 0..4, for channel c:
- b0: 0x43 ('C')
- b1: 0x48 ('H')
- b2: 0x30 + c
- b3: sample[15:8]
- b4: sample[7:0]

States:
- IDLE: `busy` = 0.
- SEND: if `tx_busy` = 0, register `tx_start` <= 1 and `tx_data` <= byte, then go to HOLD. Otherwise stay in SEND.
- HOLD: exactly one cycle; `tx_start` is visible; go to WAIT.
- WAIT: when `tx_busy` = 0, advance.
  - If b < 4: b++ and go to SEND.
  - Else, if the shadow mask has a higher enabled channel: select it, set b = 0, go to SEND.
  - Else: pulse `frame_done` and go to IDLE.

Other behaviour:
- Channels are sent in ascending order; disabled channels are skipped with no extra cycles.
- `ch_mask` changes mid-burst have no effect until the next snapshot.

## Timing
- Reset values: `tx_start` 0, `tx_data` 0x00, `busy` 0, `frame_done` 0, `overrun_count` 0, `dec` 0, `sc_q` 0, state IDLE.
- Reset asserted mid-burst clears everything immediately: no further start pulse, and the UART byte in flight is abandoned.
- Latency, with edge cycle E and idle UART:
  - SEND in E+1
  - `tx_start` high in E+2 with `tx_data` = 0x43
  - WAIT from E+3
- `tx_start` is never high for 2 consecutive cycles. It is never asserted while `tx_busy` = 1 is sampled in SEND.
- `uart_tx` contract: `tx_busy` rises no later than 1 cycle after it samples `tx_start`. The HOLD cycle covers this.
- `busy` is high from E+1 through the cycle in which `frame_done` pulses. It is low the cycle after.
- Edge in the same cycle as the `frame_done` pulse: state is still WAIT, so this counts as an overrun. An edge the next cycle is accepted.

## Test plan
- All channels, fast UART: DECIMATE=1, mask 4'b1111, samples 0x1234 / 0xFFFE / 0x0000 / 0x7FFF. Required bytes, in order: 43 48 30 12 34, 43 48 31 FF FE, 43 48 32 00 00, 43 48 33 7F FF. `frame_done` pulses once.
- Sparse mask: mask 4'b0101, same samples. Exactly 10 bytes (channels 0 and 2); ch_id bytes 0x30 and 0x32.
- Overrun and saturation: UART model busy for 100 cycles per byte, edges every 50 cycles, DECIMATE=1.
  - Bytes match the first snapshot only.
  - `overrun_count` increments once per edge during the burst and saturates at 255 after more than 255 edges.
- Decimation: DECIMATE=4, 8 edges spaced 2000 cycles apart with mask 4'b0001. Exactly 2 bursts; captures on edges 1 and 5.
- Reset mid-burst: assert `rst_n` low during byte 3 of channel 1.
  - All outputs go to reset values immediately.
  - After release, the next edge restarts at 0x43 for channel 0.
- Mask zero and UART back-pressure:
  - mask 0: 3 edges give no `tx_start`, `busy` stays 0, `overrun_count` stays 0.
  - `tx_busy` held high: SEND stalls with `tx_start` = 0 until it drops.
